// File: rtl/mux_pkg.sv
// Shared defaults and width helpers for the scanning channel multiplexer.
package mux_pkg;
  localparam int W_DEF   = 4;
  localparam int N_DEF   = 4;
  localparam int DIV_DEF = 1000;

  // Select width: ceil(log2(n)), never below one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// DIV-modulo dwell counter; tick is high on the enabled cycle that wraps it.
module scan_prescaler
  import mux_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || tick) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mux_scan_n.sv
// N-channel data mux with direct select or timed auto-scan; all outputs registered.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int N   = N_DEF,
  parameter int DIV = DIV_DEF,
  localparam int SW = sel_w(N)
) (
  input  logic           CLK,
  input  logic           R,
  input  logic           EN,
  input  logic           MODE,
  input  logic [SW-1:0]  SEL,
  input  logic [N*W-1:0] ENT,
  output logic [W-1:0]   OUT,
  output logic [SW-1:0]  CH,
  output logic [N-1:0]   AN,
  output logic           STEP
);
  logic          tick;
  logic [SW-1:0] ch_next;
  logic [W-1:0]  out_next;
  logic [N-1:0]  an_next;

  // Direct mode holds the dwell counter cleared so a later scan starts fresh.
  scan_prescaler #(.DIV(DIV)) u_pre (
    .clk  (CLK),
    .rst  (R),
    .en   (EN),
    .clr  (!MODE),
    .tick (tick)
  );

  always_comb begin
    ch_next = CH;
    if (!MODE)                ch_next = SEL;
    else if (int'(CH) >= N)   ch_next = '0;
    else if (tick)            ch_next = (int'(CH) == N - 1) ? '0 : CH + SW'(1);

    // Out-of-range channels decode to blank data and no enable.
    out_next = '0;
    an_next  = '0;
    for (int k = 0; k < N; k++) begin
      if (ch_next == SW'(k)) begin
        out_next   = ENT[k*W +: W];
        an_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      OUT  <= '0;
      CH   <= '0;
      AN   <= '0;
      STEP <= 1'b0;
    end else begin
      STEP <= tick;
      if (EN) begin
        CH  <= ch_next;
        OUT <= out_next;
        AN  <= an_next;
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n across three parameter sets (DIV=3, N=3, DIV=1).
module tb_mux_scan_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: W=4 N=4 DIV=3
  logic ra = 1, ena = 0, modea = 0; logic [1:0] sela = 0; logic [15:0] enta = 0;
  logic [3:0] outa; logic [1:0] cha; logic [3:0] ana; logic stepa;
  // B: W=4 N=3 DIV=1000
  logic rb = 1, enb = 0, modeb = 0; logic [1:0] selb = 0; logic [11:0] entb = 0;
  logic [3:0] outb; logic [1:0] chb; logic [2:0] anb; logic stepb;
  // C: W=2 N=2 DIV=1
  logic rc = 1, enc = 0, modec = 0; logic [0:0] selc = 0; logic [3:0] entc = 0;
  logic [1:0] outc; logic [0:0] chc; logic [1:0] anc; logic stepc;

  mux_scan_n #(.W(4), .N(4), .DIV(3)) dut_a (
    .CLK(clk), .R(ra), .EN(ena), .MODE(modea), .SEL(sela), .ENT(enta),
    .OUT(outa), .CH(cha), .AN(ana), .STEP(stepa));
  mux_scan_n #(.W(4), .N(3), .DIV(1000)) dut_b (
    .CLK(clk), .R(rb), .EN(enb), .MODE(modeb), .SEL(selb), .ENT(entb),
    .OUT(outb), .CH(chb), .AN(anb), .STEP(stepb));
  mux_scan_n #(.W(2), .N(2), .DIV(1)) dut_c (
    .CLK(clk), .R(rc), .EN(enc), .MODE(modec), .SEL(selc), .ENT(entc),
    .OUT(outc), .CH(chc), .AN(anc), .STEP(stepc));

  typedef struct {
    int         d;
    string      tag;
    logic [3:0] o;
    logic [1:0] c;
    logic [3:0] a;
    logic       s;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic void check_val(string nm, logic [3:0] act, logic [3:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endfunction

  function automatic logic [3:0] nib(logic [15:0] ent, int ch);
    logic [15:0] t;
    t = ent >> (4 * ch);
    return t[3:0];
  endfunction

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic cyc(input int d, input string tag, input logic r, input logic en,
                     input logic mode, input logic [1:0] sel, input logic [15:0] ent,
                     input logic [3:0] eo, input logic [1:0] ec, input logic [3:0] ea,
                     input logic es);
    exp_t e;
    @(negedge clk);
    case (d)
      0: begin ra = r; ena = en; modea = mode; sela = sel; enta = ent; end
      1: begin rb = r; enb = en; modeb = mode; selb = sel; entb = ent[11:0]; end
      default: begin rc = r; enc = en; modec = mode; selc = sel[0]; entc = ent[3:0]; end
    endcase
    e.d = d; e.tag = tag; e.o = eo; e.c = ec; e.a = ea; e.s = es;
    q.push_back(e);
  endtask

  // Monitor: after each edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    logic [3:0] o, a;
    logic [1:0] c;
    logic s;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.d)
          0: begin o = outa; c = cha; a = ana; s = stepa; end
          1: begin o = outb; c = chb; a = {1'b0, anb}; s = stepb; end
          default: begin o = {2'b0, outc}; c = {1'b0, chc}; a = {2'b0, anc}; s = stepc; end
        endcase
        check_val({e.tag, ".out"},  o, e.o);
        check_val({e.tag, ".ch"},   {2'b0, c}, {2'b0, e.c});
        check_val({e.tag, ".an"},   a, e.a);
        check_val({e.tag, ".step"}, {3'b0, s}, {3'b0, e.s});
      end
    end
  end

  initial begin
    int c;
    // ---- A: direct select
    cyc(0, "a_rst",  1, 1, 1, 0, 16'hD2A7, 4'h0, 2'd0, 4'b0000, 0);
    cyc(0, "a_sel2", 0, 1, 0, 2, 16'hD2A7, 4'h2, 2'd2, 4'b0100, 0);
    cyc(0, "a_sel3", 0, 1, 0, 3, 16'hD2A7, 4'hD, 2'd3, 4'b1000, 0);
    cyc(0, "a_sel0", 0, 1, 0, 0, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 0);
    // ---- A: auto-scan from reset, DIV=3
    cyc(0, "a_rst2", 1, 1, 0, 0, 16'hD2A7, 4'h0, 2'd0, 4'b0000, 0);
    for (int i = 1; i <= 12; i++) begin
      c = (i / 3) % 4;
      cyc(0, "a_scan", 0, 1, 1, 0, 16'hD2A7, nib(16'hD2A7, c), 2'(c), 4'(1 << c), (i % 3 == 0));
    end
    // ---- A: freeze mid-dwell, then the remaining count resumes
    cyc(0, "a_pre",  0, 1, 1, 0, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, "a_frz", 0, 0, 1, 0, 16'hFFFF, 4'h7, 2'd0, 4'b0001, 0);
    cyc(0, "a_res0", 0, 1, 1, 0, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 0);
    cyc(0, "a_res1", 0, 1, 1, 0, 16'hD2A7, 4'hA, 2'd1, 4'b0010, 1);
    cyc(0, "a_d1",   0, 1, 1, 0, 16'hD2A7, 4'hA, 2'd1, 4'b0010, 0);
    cyc(0, "a_d2",   0, 1, 1, 0, 16'hD2A7, 4'hA, 2'd1, 4'b0010, 0);
    cyc(0, "a_ch2",  0, 1, 1, 0, 16'hD2A7, 4'h2, 2'd2, 4'b0100, 1);
    cyc(0, "a_mid",  0, 1, 1, 0, 16'hD2A7, 4'h2, 2'd2, 4'b0100, 0);
    // ---- A: reset mid-dwell abandons it
    cyc(0, "a_rstm", 1, 1, 1, 0, 16'hD2A7, 4'h0, 2'd0, 4'b0000, 0);
    cyc(0, "a_pr1",  0, 1, 1, 0, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 0);
    cyc(0, "a_pr2",  0, 1, 1, 0, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 0);
    cyc(0, "a_pr3",  0, 1, 1, 0, 16'hD2A7, 4'hA, 2'd1, 4'b0010, 1);
    // ---- A: mode switches
    cyc(0, "a_m0",   0, 1, 0, 3, 16'hD2A7, 4'hD, 2'd3, 4'b1000, 0);
    cyc(0, "a_m1a",  0, 1, 1, 0, 16'hD2A7, 4'hD, 2'd3, 4'b1000, 0);
    cyc(0, "a_m1b",  0, 1, 1, 0, 16'hD2A7, 4'hD, 2'd3, 4'b1000, 0);
    cyc(0, "a_m1c",  0, 1, 1, 0, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 1);
    cyc(0, "a_dhold",0, 0, 0, 2, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 0);
    cyc(0, "a_dgo",  0, 1, 0, 2, 16'hD2A7, 4'h2, 2'd2, 4'b0100, 0);
    // ---- A: reset beats EN=0; AN stays blank until enabled
    cyc(0, "a_rsten",0, 0, 0, 2, 16'hD2A7, 4'h2, 2'd2, 4'b0100, 0);
    cyc(0, "a_rst3", 1, 0, 1, 2, 16'hD2A7, 4'h0, 2'd0, 4'b0000, 0);
    cyc(0, "a_blank",0, 0, 1, 2, 16'hD2A7, 4'h0, 2'd0, 4'b0000, 0);
    cyc(0, "a_first",0, 1, 1, 2, 16'hD2A7, 4'h7, 2'd0, 4'b0001, 0);
    // ---- B: N=3 out-of-range select, recovery, live data tracking
    cyc(1, "b_rst",  1, 1, 0, 0, 16'h05C9, 4'h0, 2'd0, 4'b0000, 0);
    cyc(1, "b_sel3", 0, 1, 0, 3, 16'h05C9, 4'h0, 2'd3, 4'b0000, 0);
    cyc(1, "b_fix",  0, 1, 1, 3, 16'h05C9, 4'h9, 2'd0, 4'b0001, 0);
    cyc(1, "b_trk1", 0, 1, 1, 3, 16'h05C4, 4'h4, 2'd0, 4'b0001, 0);
    cyc(1, "b_trk2", 0, 1, 1, 3, 16'h05CE, 4'hE, 2'd0, 4'b0001, 0);
    cyc(1, "b_sel2", 0, 1, 0, 2, 16'h05C9, 4'h5, 2'd2, 4'b0100, 0);
    cyc(1, "b_sel1", 0, 1, 0, 1, 16'h05C9, 4'hC, 2'd1, 4'b0010, 0);
    // ---- C: DIV=1 advances every enabled cycle
    cyc(2, "c_rst",  1, 1, 1, 0, 16'h0009, 4'h0, 2'd0, 4'b0000, 0);
    cyc(2, "c_s1",   0, 1, 1, 0, 16'h0009, 4'h2, 2'd1, 4'b0010, 1);
    cyc(2, "c_s2",   0, 1, 1, 0, 16'h0009, 4'h1, 2'd0, 4'b0001, 1);
    cyc(2, "c_s3",   0, 1, 1, 0, 16'h0009, 4'h2, 2'd1, 4'b0010, 1);
    cyc(2, "c_hold", 0, 0, 1, 0, 16'h0009, 4'h2, 2'd1, 4'b0010, 0);
    cyc(2, "c_dir",  0, 1, 0, 0, 16'h0009, 4'h1, 2'd0, 4'b0001, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
